// File: rtl/main_mem_responder.sv
// Memory-side responder for the data cache: wrapped critical-word-first refill bursts
// and byte-strobed write-through stores behind a valid/ready handshake with fixed latency.
module main_mem_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 4,
  parameter int BURST_LEN       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int IDX_W  = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [WORD_W-1:0] DEPTH_W   = WORD_W'(MEM_DEPTH_WORDS);
  localparam logic [WORD_W-1:0] LINE_MASK = WORD_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q;
  logic [LAT_W-1:0]      lat_cnt_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic                  write_q;
  logic [WORD_W-1:0]     word_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  last_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  logic                  oor;
  logic                  present;
  logic                  mem_we;
  logic [BEAT_W-1:0]     next_beat;
  logic [WORD_W-1:0]     beat_word;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  unused_bits;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_last  = last_q;
  assign resp_err   = err_q;

  // The beat being loaded is beat 0 when leaving WAIT, otherwise the one after the current beat.
  always_comb begin
    oor       = (word_q >= DEPTH_W);
    present   = (state_q == WAIT) && (lat_cnt_q == '0);
    mem_we    = present && write_q && !oor;
    next_beat = (state_q == RESP) ? beat_cnt_q + BEAT_W'(1) : '0;
    beat_word = (word_q & ~LINE_MASK) | ((word_q + WORD_W'(next_beat)) & LINE_MASK);
    beat_data = oor ? '0 : mem[beat_word[IDX_W-1:0]];
  end

  assign unused_bits = ^{req_addr[1:0], beat_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
      write_q    <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            word_q     <= req_addr[ADDR_WIDTH-1:2];
            wdata_q    <= req_wdata;
            wstrb_q    <= req_wstrb;
            lat_cnt_q  <= LAT_INIT;
            beat_cnt_q <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_q == '0) begin
            state_q <= RESP;
            err_q   <= oor;
            if (write_q) begin
              rdata_q <= '0;
              last_q  <= 1'b1;
            end else begin
              rdata_q <= beat_data;
              last_q  <= (LAST_BEAT == '0);
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              rdata_q <= '0;
              last_q  <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              beat_cnt_q <= next_beat;
              rdata_q    <= beat_data;
              last_q     <= (next_beat == LAST_BEAT);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store lands on the same edge that raises resp_valid; state is IDLE under reset, so no partial write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[word_q[IDX_W-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized self-checking bench for main_mem_responder against a word-array reference model.
module tb_main_mem_responder;

  localparam int LAT   = 4;
  localparam int BL    = 4;
  localparam int DEPTH = 1024;
  localparam int MODEL_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_last;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [MODEL_WORDS];

  main_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_last(resp_last), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_word(input logic [31:0] addr, input int i);
    int w;
    int base;
    w    = int'(addr >> 2);
    base = w - (w % BL);
    return base + ((w % BL) + i) % BL;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] w;
    w = addr >> 2;
    if (w < MODEL_WORDS) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[w][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_last"}, 32'(resp_last), 32'd0);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
  endtask

  task automatic run_req(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int stall_beat, input int stall_len,
                         input int abort_beat, output logic [31:0] beat0);
    bit oor;
    int nb;
    logic [31:0] exp_d;
    logic exp_last;
    oor   = (addr >> 2) >= DEPTH;
    beat0 = 'x;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_after_accept", 32'(req_ready), 32'd0);
    if (w && !oor) model_write(addr, wdata, strb);
    for (int c = 0; c < LAT; c++) begin
      check("valid_early", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    nb = w ? 1 : BL;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_beat) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      exp_d = '0;
      if (!w && !oor) exp_d = model[exp_word(addr, i)];
      exp_last = w ? 1'b1 : (i == BL - 1);
      if (i == stall_beat) begin
        resp_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          check("stall_valid", 32'(resp_valid), 32'd1);
          check("stall_rdata", resp_rdata, exp_d);
          check("stall_last", 32'(resp_last), 32'(exp_last));
        end
        resp_ready = 1'b1;
      end
      check("beat_valid", 32'(resp_valid), 32'd1);
      check("beat_rdata", resp_rdata, exp_d);
      check("beat_last", 32'(resp_last), 32'(exp_last));
      check("beat_err", 32'(resp_err), 32'(oor));
      check("beat_ready_low", 32'(req_ready), 32'd0);
      if (i == 0) beat0 = resp_rdata;
      @(posedge clk); #1;
    end
    check("done_valid", 32'(resp_valid), 32'd0);
    check("done_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] b0;
    bit rw, roor;
    logic [31:0] raddr;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // store first, then fill the rest of the modelled region with distinct values
    run_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, 0, -1, b0);
    check("t1_ack_rdata", b0, 32'd0);
    for (int wi = 0; wi < MODEL_WORDS; wi++) begin
      if (wi == 4) continue;
      run_req(1'b1, 32'(wi * 4), $urandom, 4'hF, -1, 0, -1, b0);
    end

    run_req(1'b0, 32'h18, '0, '0, -1, 0, -1, b0);
    check("t2_crit_word", b0, model[6]);

    run_req(1'b1, 32'h10, 32'h00AA0000, 4'b0100, -1, 0, -1, b0);
    run_req(1'b0, 32'h10, '0, '0, -1, 0, -1, b0);
    check("t3_merge", b0, 32'hDEAABEEF);

    run_req(1'b0, 32'h20, '0, '0, 2, 3, -1, b0);

    run_req(1'b0, 32'(4 * DEPTH), '0, '0, -1, 0, -1, b0);
    run_req(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, -1, 0, -1, b0);
    run_req(1'b0, 32'h0, '0, '0, -1, 0, -1, b0);

    run_req(1'b1, 32'h24, 32'h12345678, 4'b0000, -1, 0, -1, b0);
    run_req(1'b0, 32'h24, '0, '0, -1, 0, -1, b0);

    run_req(1'b0, 32'h30, '0, '0, -1, 0, 2, b0);
    run_req(1'b0, 32'h30, '0, '0, -1, 0, -1, b0);

    for (int n = 0; n < 60; n++) begin
      rw    = 1'($urandom_range(0, 1));
      roor  = ($urandom_range(0, 7) == 0);
      raddr = roor ? 32'(4 * DEPTH) + 32'($urandom_range(0, 1023))
                   : 32'($urandom_range(0, MODEL_WORDS * 4 - 1));
      run_req(rw, raddr, $urandom, 4'($urandom), $urandom_range(0, BL), $urandom_range(1, 4), -1, b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
